// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES control-register definitions: field widths, field offsets of the
// packed control word, the control-word struct, an unpack helper and the
// error-cause encoding reported by the shadowed-register writer.
// No ports (package).
// -----------------------------------------------------------------------------
package aes_pkg;

  // Field widths of the AES control register
  localparam int AES_OP_WIDTH             = 2;
  localparam int AES_MODE_WIDTH           = 6;
  localparam int AES_KEYLEN_WIDTH         = 3;
  localparam int AES_SIDELOAD_WIDTH       = 1;
  localparam int AES_PRNGRESEEDRATE_WIDTH = 3;
  localparam int AES_MANUALOP_WIDTH       = 1;

  // Field offsets inside the packed 16-bit control word
  localparam int CTRL_MANUAL_OP_OFFSET        = 0;
  localparam int CTRL_PRNG_RESEED_RATE_OFFSET = CTRL_MANUAL_OP_OFFSET + AES_MANUALOP_WIDTH;
  localparam int CTRL_SIDELOAD_OFFSET         = CTRL_PRNG_RESEED_RATE_OFFSET + AES_PRNGRESEEDRATE_WIDTH;
  localparam int CTRL_KEY_LEN_OFFSET          = CTRL_SIDELOAD_OFFSET + AES_SIDELOAD_WIDTH;
  localparam int CTRL_MODE_OFFSET             = CTRL_KEY_LEN_OFFSET + AES_KEYLEN_WIDTH;
  localparam int CTRL_OPERATION_OFFSET        = CTRL_MODE_OFFSET + AES_MODE_WIDTH;
  localparam int CTRL_WIDTH                   = CTRL_OPERATION_OFFSET + AES_OP_WIDTH;

  typedef struct packed {
    logic [AES_OP_WIDTH-1:0]             operation;
    logic [AES_MODE_WIDTH-1:0]           mode;
    logic [AES_KEYLEN_WIDTH-1:0]         key_len;
    logic [AES_SIDELOAD_WIDTH-1:0]       sideload;
    logic [AES_PRNGRESEEDRATE_WIDTH-1:0] prng_reseed_rate;
    logic [AES_MANUALOP_WIDTH-1:0]       manual_operation;
  } ctrl_reg_t;

  // Failure cause reported alongside err_o
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_TIMEOUT  = 3'd1,
    ERR_PHASE    = 3'd2,
    ERR_UPDATE   = 3'd3,
    ERR_MISMATCH = 3'd4,
    ERR_STORAGE  = 3'd5
  } err_code_e;

  // Build the control struct from a raw word using the shared offsets
  function automatic ctrl_reg_t ctrl_unpack(input logic [CTRL_WIDTH-1:0] raw);
    ctrl_reg_t c;
    c.operation        = raw[CTRL_OPERATION_OFFSET        +: AES_OP_WIDTH];
    c.mode             = raw[CTRL_MODE_OFFSET             +: AES_MODE_WIDTH];
    c.key_len          = raw[CTRL_KEY_LEN_OFFSET          +: AES_KEYLEN_WIDTH];
    c.sideload         = raw[CTRL_SIDELOAD_OFFSET         +: AES_SIDELOAD_WIDTH];
    c.prng_reseed_rate = raw[CTRL_PRNG_RESEED_RATE_OFFSET +: AES_PRNGRESEEDRATE_WIDTH];
    c.manual_operation = raw[CTRL_MANUAL_OP_OFFSET        +: AES_MANUALOP_WIDTH];
    return c;
  endfunction

endpackage

// File: rtl/aes_ctrl_shadow_writer.sv
// -----------------------------------------------------------------------------
// aes_ctrl_shadow_writer
// Programs the shadowed AES control register: waits for the core to go idle,
// performs the double-write sequence, checks the shadow phase / update error
// after each write, retries phase and update failures up to MaxRetries times,
// and reports success (done_o) or a failure cause (err_o, err_code_o).
// A storage error is fatal and holds the block in ERROR until reset.
//
// Optional feature: define AES_CTRL_SHADOW_READBACK_EN to add a READBACK state
// that compares the committed value rdata_i against the requested config.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_i, cfg_i[15:0]      program request and packed config word
//   busy_o                  high whenever the FSM is not IDLE
//   done_o, err_o           one-cycle success / failure pulses
//   err_code_o[2:0]         failure cause, valid with err_o
//   fatal_o                 sticky storage error
//   we_o, wdata_o[15:0]     shadowed write strobe and data (0 when idle)
//   idle_i                  AES core idle
//   phase_i                 shadow phase
//   err_update_i            update mismatch
//   err_storage_i           storage mismatch
//   rdata_i[15:0]           committed register value (readback build only)
// -----------------------------------------------------------------------------
module aes_ctrl_shadow_writer
  import aes_pkg::*;
#(
  parameter int MaxRetries  = 2,
  parameter int IdleTimeout = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [15:0] cfg_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  err_code_o,
  output logic        fatal_o,
  output logic        we_o,
  output logic [15:0] wdata_o,
  input  logic        idle_i,
  input  logic        phase_i,
  input  logic        err_update_i,
  input  logic        err_storage_i,
  input  logic [15:0] rdata_i
);

  localparam int RetryW = (MaxRetries < 1) ? 1 : $clog2(MaxRetries + 1);
  localparam int TmoW   = (IdleTimeout < 2) ? 1 : $clog2(IdleTimeout);

  localparam logic [RetryW-1:0] RetryMax = RetryW'(MaxRetries);
  // WAIT_IDLE is entered with the counter at 0, so the last allowed cycle
  // is the one where the counter reads IdleTimeout-1.
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(IdleTimeout - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_WR1,
    ST_CHK1,
    ST_WR2,
    ST_CHK2,
`ifdef AES_CTRL_SHADOW_READBACK_EN
    ST_READBACK,
`endif
    ST_DONE,
    ST_ERROR
  } state_e;

  state_e            state_q;
  ctrl_reg_t         cfg_q;
  logic [RetryW-1:0] retry_q;
  logic [TmoW-1:0]   tmo_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  err_code_e         err_code_q;
  logic              fatal_q;
  logic              we_q;

  // Failure cause of the current check state, ERR_NONE when the check passes
  err_code_e         chk_code_d;

  always_comb begin
    chk_code_d = ERR_NONE;
    if (state_q == ST_CHK1) begin
      if (!phase_i) chk_code_d = ERR_PHASE;
    end else if (state_q == ST_CHK2) begin
      // An update mismatch takes precedence over a stuck phase
      if (err_update_i)  chk_code_d = ERR_UPDATE;
      else if (phase_i)  chk_code_d = ERR_PHASE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      retry_q    <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      fatal_q    <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      we_q       <= 1'b0;

      if (state_q != ST_IDLE && err_storage_i) begin
        // Storage corruption overrides every other transition. Once fatal,
        // the failure has already been reported, so no further pulses.
        state_q <= ST_ERROR;
        busy_q  <= 1'b1;
        fatal_q <= 1'b1;
        if (!fatal_q) begin
          err_q      <= 1'b1;
          err_code_q <= ERR_STORAGE;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (req_i && !fatal_q) begin
              cfg_q   <= ctrl_unpack(cfg_i);
              retry_q <= '0;
              tmo_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_WAIT_IDLE;
            end
          end

          ST_WAIT_IDLE: begin
            if (idle_i) begin
              we_q    <= 1'b1;
              state_q <= ST_WR1;
            end else if (tmo_q == TmoLast) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_TIMEOUT;
              state_q    <= ST_ERROR;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end

          ST_WR1: state_q <= ST_CHK1;

          ST_WR2: state_q <= ST_CHK2;

          ST_CHK1, ST_CHK2: begin
            if (chk_code_d != ERR_NONE) begin
              if (retry_q < RetryMax) begin
                retry_q <= retry_q + 1'b1;
                tmo_q   <= '0;
                state_q <= ST_WAIT_IDLE;
              end else begin
                err_q      <= 1'b1;
                err_code_q <= chk_code_d;
                state_q    <= ST_ERROR;
              end
            end else if (state_q == ST_CHK1) begin
              we_q    <= 1'b1;
              state_q <= ST_WR2;
            end else begin
`ifdef AES_CTRL_SHADOW_READBACK_EN
              state_q <= ST_READBACK;
`else
              done_q  <= 1'b1;
              state_q <= ST_DONE;
`endif
            end
          end

`ifdef AES_CTRL_SHADOW_READBACK_EN
          ST_READBACK: begin
            // A differing committed value means the register legalised the
            // request; rewriting would give the same result, so no retry.
            if (cfg_q == rdata_i) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_MISMATCH;
              state_q    <= ST_ERROR;
            end
          end
`endif

          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end

          ST_ERROR: begin
            if (!fatal_q) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end

          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifndef AES_CTRL_SHADOW_READBACK_EN
  // Readback is compiled out; the port is kept for a uniform interface
  logic unused_rdata;
  assign unused_rdata = ^rdata_i;
`endif

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign fatal_o    = fatal_q;
  assign we_o       = we_q;
  assign wdata_o    = we_q ? cfg_q : '0;

endmodule
